// File: rtl/switch_debouncer.sv
// Per-channel switch debouncer: 2-flop synchroniser, stable-count filter, rise/fall pulses.
// Define DEBOUNCE_BYPASS_EN to drop the counters and pass the synchronised level straight through.
module switch_debouncer #(
  parameter int   WIDTH         = 3,
  parameter int   STABLE_CYCLES = 50000,
  parameter int   CNT_W         = 16,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             settled
);

  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RST_VAL}};

  // Counter must reach STABLE_CYCLES-1 without wrapping; flag bad configurations at elaboration.
  if (STABLE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(STABLE_CYCLES - 1)) begin : g_cfg_err
    $error("switch_debouncer: STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             settled_q, settled_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= RST_VEC;
      s2_q      <= RST_VEC;
      clean_q   <= RST_VEC;
      rise_q    <= '0;
      fall_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      s1_q      <= sw_raw;
      s2_q      <= s1_q;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      settled_q <= settled_d;
    end
  end

`ifndef DEBOUNCE_BYPASS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Any return of s2 to the accepted level clears the count, aborting the transition.
  always_comb begin
    clean_d   = clean_q;
    rise_d    = '0;
    fall_d    = '0;
    settled_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = s2_q[i];
          rise_d[i]  = s2_q[i];
          fall_d[i]  = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (cnt_d[i] != '0) settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  // Clean tracks the value s2 takes this edge, so a raw change appears two edges later.
  always_comb begin
    clean_d   = s1_q;
    rise_d    = s1_q & ~clean_q;
    fall_d    = ~s1_q & clean_q;
    settled_d = 1'b1;
  end
`endif

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign settled  = settled_q;

endmodule
